// File: rtl/mfda_fluid_pkg.sv
// rtl/mfda_fluid_pkg.sv - shared types and constants for the inlet pump sequencer
//   fluid_state_e     : dosing FSM states
//   PUMP_PATTERN      : per-step valve closure pattern of one peristaltic stroke
//   VALVES_ALL_CLOSED : idle pump valve pattern
package mfda_fluid_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        OPEN   = 3'd1,
        PUMP   = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } fluid_state_e;

    localparam int PUMP_STEPS = 6;

    localparam logic [2:0] VALVES_ALL_CLOSED = 3'b111;

    // None of these steps is 3'b000, so the open inlet is always isolated
    // from at least one pump chamber.
    localparam logic [2:0] PUMP_PATTERN [PUMP_STEPS] = '{
        3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
    };

endpackage

// File: rtl/peristaltic_phase_gen.sv
// rtl/peristaltic_phase_gen.sv - six-step peristaltic pump phase generator
//   clk, rst_n   : clock, asynchronous active-low reset
//   run          : advance the step sequence
//   clear        : return to step 0 with a full hold count
//   pump_closed  : valve closure pattern (all closed when not running)
//   stroke_tick  : pulses on the last cycle of step 5
module peristaltic_phase_gen
    import mfda_fluid_pkg::*;
#(
    parameter int PHASE_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    output logic [2:0] pump_closed,
    output logic       stroke_tick
);

    localparam int HOLD_W = $clog2(PHASE_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(PHASE_HOLD - 1);
    localparam logic [2:0] LAST_STEP = 3'(PUMP_STEPS - 1);

    logic [HOLD_W-1:0] hold_q;
    logic [2:0]        step_q;
    logic              step_end;

    assign step_end = (hold_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= HOLD_RELOAD;
            step_q <= 3'd0;
        end else if (clear) begin
            hold_q <= HOLD_RELOAD;
            step_q <= 3'd0;
        end else if (run) begin
            if (step_end) begin
                hold_q <= HOLD_RELOAD;
                step_q <= (step_q == LAST_STEP) ? 3'd0 : step_q + 3'd1;
            end else begin
                hold_q <= hold_q - HOLD_W'(1);
            end
        end
    end

    assign stroke_tick = run && !clear && step_end && (step_q == LAST_STEP);

    // Decoded only from registered state (run comes from the parent's state
    // register), so no input-to-valve combinational path exists.
    assign pump_closed = run ? PUMP_PATTERN[step_q] : VALVES_ALL_CLOSED;

endmodule

// File: rtl/inlet_pump_sequencer.sv
// rtl/inlet_pump_sequencer.sv - command-driven soln1 inlet and peristaltic pump dosing FSM
//   cmd_valid/cmd_ready/cmd_strokes/cmd_settle : dose command handshake
//   abort        : cancel the dose in progress
//   inlet_open   : soln1 inlet valve drive
//   pump_closed  : peristaltic pump valve drive (1 = closed)
//   busy         : not idle
//   strokes_done : strokes completed for current/last dose
//   done/aborted : single-cycle completion pulses
module inlet_pump_sequencer
    import mfda_fluid_pkg::*;
#(
    parameter int STROKE_W   = 8,
    parameter int SETTLE_W   = 16,
    parameter int PHASE_HOLD = 4,
    parameter int OPEN_DELAY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [STROKE_W-1:0] cmd_strokes,
    input  logic [SETTLE_W-1:0] cmd_settle,
    input  logic                abort,
    output logic                inlet_open,
    output logic [2:0]          pump_closed,
    output logic                busy,
    output logic [STROKE_W-1:0] strokes_done,
    output logic                done,
    output logic                aborted
);

    localparam int OPEN_W = $clog2(OPEN_DELAY + 1);
    localparam logic [OPEN_W-1:0] OPEN_RELOAD = OPEN_W'(OPEN_DELAY - 1);

    fluid_state_e        state_q, state_d;
    logic [STROKE_W-1:0] strokes_q, strokes_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [OPEN_W-1:0]   open_cnt_q, open_cnt_d;
    logic [STROKE_W-1:0] strokes_done_q, strokes_done_d;
    logic                inlet_q, inlet_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic                accept;
    logic                pump_run;
    logic                stroke_tick;
    logic [STROKE_W-1:0] strokes_done_inc;

    assign cmd_ready        = (state_q == IDLE) && !abort;
    assign accept           = cmd_valid && cmd_ready;
    assign pump_run         = (state_q == PUMP);
    assign strokes_done_inc = strokes_done_q + STROKE_W'(1);

    peristaltic_phase_gen #(
        .PHASE_HOLD (PHASE_HOLD)
    ) u_phase_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (pump_run),
        .clear       (!pump_run),
        .pump_closed (pump_closed),
        .stroke_tick (stroke_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            strokes_q      <= '0;
            settle_q       <= '0;
            settle_cnt_q   <= '0;
            open_cnt_q     <= '0;
            strokes_done_q <= '0;
            inlet_q        <= 1'b0;
            done_q         <= 1'b0;
            aborted_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            strokes_q      <= strokes_d;
            settle_q       <= settle_d;
            settle_cnt_q   <= settle_cnt_d;
            open_cnt_q     <= open_cnt_d;
            strokes_done_q <= strokes_done_d;
            inlet_q        <= inlet_d;
            done_q         <= done_d;
            aborted_q      <= aborted_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        strokes_d      = strokes_q;
        settle_d       = settle_q;
        settle_cnt_d   = settle_cnt_q;
        open_cnt_d     = open_cnt_q;
        strokes_done_d = strokes_done_q;
        inlet_d        = inlet_q;
        done_d         = 1'b0;
        aborted_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    strokes_d      = cmd_strokes;
                    settle_d       = cmd_settle;
                    strokes_done_d = '0;
                    if (cmd_strokes == '0) begin
                        // Nothing to pump: skip straight to settling, valves untouched.
                        state_d      = SETTLE;
                        settle_cnt_d = cmd_settle;
                    end else begin
                        state_d    = OPEN;
                        open_cnt_d = OPEN_RELOAD;
                        inlet_d    = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (open_cnt_q == '0) begin
                    state_d = PUMP;
                end else begin
                    open_cnt_d = open_cnt_q - OPEN_W'(1);
                end
            end
            PUMP: begin
                if (stroke_tick) begin
                    if (strokes_done_q < strokes_q) begin
                        strokes_done_d = strokes_done_inc;
                    end
                    if ((strokes_done_inc == strokes_q) || (strokes_done_q >= strokes_q)) begin
                        state_d      = SETTLE;
                        inlet_d      = 1'b0;
                        settle_cnt_d = settle_q;
                    end
                end
            end
            SETTLE: begin
                // A count of N occupies exactly N cycles here; 0 behaves like 1.
                if (settle_cnt_q <= SETTLE_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                inlet_d = 1'b0;
            end
        endcase

        // Abort overrides every non-idle transition; the partial stroke count is kept.
        if (abort && (state_q != IDLE)) begin
            state_d        = IDLE;
            inlet_d        = 1'b0;
            done_d         = 1'b0;
            aborted_d      = 1'b1;
            strokes_done_d = strokes_done_q;
        end
    end

    assign inlet_open   = inlet_q;
    assign busy         = (state_q != IDLE);
    assign strokes_done = strokes_done_q;
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule
